// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle AND/OR/ADD/SUB, bit-serial shifts and shift-and-add multiply.
// valid/ready on both sides; the result is held in DONE until the consumer takes it.
module seq_alu #(
   parameter int WIDTH = 64,
   parameter int SHW   = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       Operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_MUL   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_SRL = 4'b0100;
   localparam logic [3:0] OP_SRA = 4'b0101;
   localparam logic [3:0] OP_MUL = 4'b1000;

   // One extra counter bit so a full WIDTH-iteration multiply fits.
   localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
   localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);

   logic [1:0]       state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [SHW:0]     cnt_q, cnt_d;
   logic             ill_q, ill_d;
   logic [SHW-1:0]   shamt;

   assign shamt     = b[SHW-1:0];
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = res_q;
   assign zero      = (res_q == '0);
   assign illegal   = ill_q;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      res_d    = res_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      ill_d    = ill_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d    = Operation;
               ill_d   = 1'b0;
               state_d = ST_DONE;
               case (Operation)
                  OP_AND: res_d = a & b;
                  OP_OR:  res_d = a | b;
                  OP_ADD: res_d = a + b;
                  OP_SUB: res_d = a - b;
                  OP_SLL, OP_SRL, OP_SRA: begin
                     res_d = a;
                     cnt_d = {1'b0, shamt};
                     if (shamt != '0) state_d = ST_SHIFT;
                  end
                  OP_MUL: begin
                     res_d    = '0;
                     mcand_d  = a;
                     mplier_d = b;
                     cnt_d    = CNT_MUL;
                     state_d  = ST_MUL;
                  end
                  default: begin
                     res_d = '0;
                     ill_d = 1'b1;
                  end
               endcase
            end
         end
         ST_SHIFT: begin
            case (op_q)
               OP_SLL:  res_d = res_q << 1;
               OP_SRL:  res_d = res_q >> 1;
               default: res_d = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
            endcase
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = ST_DONE;
         end
         ST_MUL: begin
            if (mplier_q[0]) res_d = res_q + mcand_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = ST_DONE;
         end
         default: begin
            if (out_ready) state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         res_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         res_q    <= res_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         ill_q    <= ill_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=64): latency, result, flags, backpressure and mid-op reset.
module tb_seq_alu;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  Operation;
   logic [63:0] a;
   logic [63:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic        zero;
   logic        illegal;

   int n_checks = 0;
   int n_fail   = 0;

   seq_alu #(.WIDTH(64), .SHW(6)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .Operation(Operation), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the block idle. Drives one op, then scrambles the
   // inputs so a design that fails to latch them is caught.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] aa,
                         input logic [63:0] bb, input int exp_lat, input logic [63:0] exp_res,
                         input logic exp_zero, input logic exp_ill, input int hold);
      int lat;
      check({tag, "_in_rdy"}, {63'd0, in_ready}, 64'd1);
      in_valid  = 1'b1;
      Operation = op;
      a         = aa;
      b         = bb;
      out_ready = (hold == 0);
      @(negedge clk);
      in_valid  = 1'b0;
      Operation = 4'hF;
      a         = ~aa;
      b         = ~bb;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_res"}, result, exp_res);
      check({tag, "_zero"}, {63'd0, zero}, {63'd0, exp_zero});
      check({tag, "_ill"}, {63'd0, illegal}, {63'd0, exp_ill});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_vld"}, {63'd0, out_valid}, 64'd1);
         check({tag, "_hold_res"}, result, exp_res);
         check({tag, "_hold_inrdy"}, {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, "_drop_vld"}, {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      int seen;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      Operation = 4'h0;
      a         = '0;
      b         = '0;
      #1;
      check("rst_in_rdy", {63'd0, in_ready}, 64'd1);
      check("rst_out_vld", {63'd0, out_valid}, 64'd0);
      check("rst_res", result, 64'd0);
      check("rst_zero", {63'd0, zero}, 64'd1);
      check("rst_ill", {63'd0, illegal}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      run_op("add",    4'b0010, 64'd5, 64'd7, 1, 64'd12, 1'b0, 1'b0, 0);
      run_op("sub",    4'b0110, 64'd7, 64'd7, 1, 64'd0, 1'b1, 1'b0, 0);
      run_op("and",    4'b0000, 64'hF0, 64'h3C, 1, 64'h30, 1'b0, 1'b0, 0);
      run_op("or",     4'b0001, 64'hA0, 64'h05, 1, 64'hA5, 1'b0, 1'b0, 0);
      run_op("addwrp", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1, 64'd1, 1'b0, 1'b0, 0);
      run_op("sll5",   4'b0011, 64'd1, 64'd5, 6, 64'd32, 1'b0, 1'b0, 0);
      run_op("sra2",   4'b0101, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 3,
             64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 0);
      run_op("srl0",   4'b0100, 64'h1234, 64'd0, 1, 64'h1234, 1'b0, 1'b0, 0);
      run_op("srlhi",  4'b0100, 64'h8000_0000_0000_0000, 64'h104, 5,
             64'h0800_0000_0000_0000, 1'b0, 1'b0, 0);
      run_op("sll63",  4'b0011, 64'd1, 64'd63, 64, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0);
      run_op("mul",    4'b1000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65,
             64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 1'b0, 0);
      run_op("mul2",   4'b1000, 64'h1_0000_0001, 64'h1_0000_0001, 65,
             64'h2_0000_0001, 1'b0, 1'b0, 0);
      run_op("addhld", 4'b0010, 64'd10, 64'd20, 1, 64'd30, 1'b0, 1'b0, 3);
      run_op("illeg",  4'b1111, 64'd9, 64'd9, 1, 64'd0, 1'b1, 1'b1, 0);
      run_op("illclr", 4'b0010, 64'd1, 64'd1, 1, 64'd2, 1'b0, 1'b0, 0);

      // Reset ten cycles into a multiply: nothing may come out.
      in_valid  = 1'b1;
      Operation = 4'b1000;
      a         = 64'd7;
      b         = 64'd9;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      check("mrst_out_vld", {63'd0, out_valid}, 64'd0);
      check("mrst_in_rdy", {63'd0, in_ready}, 64'd1);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mrst_no_out", 64'(seen), 64'd0);
      run_op("postrst", 4'b0010, 64'd100, 64'd23, 1, 64'd123, 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
